// File: rtl/noc_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_arb_pkg
//  Description : Shared types and helpers for the 5-port NoC router output
//                allocators: port indices, allocator state enum, a one-hot
//                decoder and a 3-bit modulo-5 adder.
//  Revision    : 1.0  initial release
// ============================================================================
package noc_arb_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_W = 3'd2;
    localparam logic [2:0] PORT_S = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    // Port index -> one-hot port vector; out-of-range indices decode to 0.
    function automatic logic [4:0] onehot5(input logic [2:0] idx);
        logic [4:0] v;
        case (idx)
            3'd0:    v = 5'b00001;
            3'd1:    v = 5'b00010;
            3'd2:    v = 5'b00100;
            3'd3:    v = 5'b01000;
            3'd4:    v = 5'b10000;
            default: v = 5'b00000;
        endcase
        return v;
    endfunction

    // (a + b) mod 5 for a, b in 0..4, kept in 3 bits: the wrap is detected
    // before the add so the intermediate never needs a fourth bit.
    function automatic logic [2:0] mod5_add(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] room;
        room = 3'd5 - b;
        if (a >= room) begin
            return a - room;
        end
        return a + b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick5.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick5
//  Description : Combinational 5-way round-robin picker. Returns the first
//                set request bit searched from ptr upward, wrapping mod 5.
//  Ports       : req[4:0]  request vector
//                ptr[2:0]  search start index (0..4)
//                any       at least one request set
//                idx[2:0]  winning index (0 when any=0)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick5
    import noc_arb_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic       any,
    output logic [2:0] idx
);

    logic [2:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest requester, which
    // is assigned last, wins.
    always_comb begin
        any    = 1'b0;
        idx    = 3'd0;
        w_cand = 3'd0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_cand = mod5_add(ptr, 3'(k));
            if (|(req & onehot5(w_cand))) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/credit_output_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : credit_output_allocator
//  Description : Per-output wormhole allocator with downstream credit
//                gating. Picks an input by round-robin, locks the output to
//                it until its tail flit is forwarded, and only lets a flit
//                through while a downstream credit is available.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                req[4:0]        input requests for this output (N,E,W,S,L)
//                tail[4:0]       head-of-queue flit is a tail, per input
//                credit_in       downstream freed one slot (pulse)
//                grant[4:0]      one-hot transfer grant, this cycle
//                xbar_sel[4:0]   one-hot crossbar select of the owner
//                valid_out       flit driven downstream this cycle
//                credit_cnt      available downstream credits
//                busy            output locked to an owner
//                credit_err      sticky credit-overflow flag
//  Revision    : 1.0  initial release
// ============================================================================
module credit_output_allocator
    import noc_arb_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       req,
    input  logic [4:0]       tail,
    input  logic             credit_in,
    output logic [4:0]       grant,
    output logic [4:0]       xbar_sel,
    output logic             valid_out,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             busy,
    output logic             credit_err
);

    localparam logic [CNT_W-1:0] c_CREDITS_MAX = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

    alloc_state_t     r_state_q, w_state_d;
    logic [2:0]       r_owner_q, w_owner_d;
    logic [2:0]       r_ptr_q,   w_ptr_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic             r_err_q,   w_err_d;

    logic [4:0]       w_owner_oh;
    logic             w_locked;
    logic             w_xfer;
    logic             w_owner_tail;
    logic             w_any;
    logic [2:0]       w_win;

    rr_pick5 u_pick (
        .req (req),
        .ptr (r_ptr_q),
        .any (w_any),
        .idx (w_win)
    );

    assign w_owner_oh   = onehot5(r_owner_q);
    assign w_locked     = (r_state_q == LOCKED);
    // A transfer needs the lock, the owner requesting and a free credit;
    // other requesters are masked out by the owner one-hot.
    assign w_xfer       = w_locked && (|(req & w_owner_oh)) && (r_cnt_q != '0);
    assign w_owner_tail = |(tail & w_owner_oh);

    always_comb begin
        w_state_d = r_state_q;
        w_owner_d = r_owner_q;
        w_ptr_d   = r_ptr_q;
        w_cnt_d   = r_cnt_q;
        w_err_d   = r_err_q;

        case (r_state_q)
            IDLE: begin
                if (w_any) begin
                    w_state_d = LOCKED;
                    w_owner_d = w_win;
                end
            end
            LOCKED: begin
                // Only a forwarded tail releases the lock; a stalled tail waits.
                if (w_xfer && w_owner_tail) begin
                    w_state_d = IDLE;
                    w_ptr_d   = mod5_add(r_owner_q, 3'd1);
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // A simultaneous transfer and return cancel, even at full count.
        case ({w_xfer, credit_in})
            2'b10: w_cnt_d = r_cnt_q - c_ONE;
            2'b01: begin
                if (r_cnt_q == c_CREDITS_MAX) begin
                    w_err_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + c_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_owner_q <= PORT_N;
            r_ptr_q   <= PORT_N;
            r_cnt_q   <= c_CREDITS_MAX;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_owner_q <= w_owner_d;
            r_ptr_q   <= w_ptr_d;
            r_cnt_q   <= w_cnt_d;
            r_err_q   <= w_err_d;
        end
    end

    assign grant      = w_xfer   ? w_owner_oh : 5'b00000;
    assign xbar_sel   = w_locked ? w_owner_oh : 5'b00000;
    assign valid_out  = w_xfer;
    assign busy       = w_locked;
    assign credit_cnt = r_cnt_q;
    assign credit_err = r_err_q;

endmodule
`default_nettype wire
